fetch_sequencer: RTL and testbench

//  Instruction-fetch controller for the RV32 core. Owns the architectural PC,

---
 rtl/fetch_sequencer.sv | 110 +++++++++++
 tb/tb_fetch_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, keeps at most one imem request in
// flight, presents fetched words to decode and squashes fetches made stale by redirects.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] redirect_offset,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic [31:0] pc
);

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    logic [1:0]  state;
    logic        drop;
    logic [31:0] target;
    logic        unused_offset_lsbs;

    // Offset low bits carry no meaning for word-aligned targets.
    assign target             = redirect_pc + {redirect_offset[31:2], 2'b00};
    assign unused_offset_lsbs = ^redirect_offset[1:0];
    assign imem_req_addr      = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            pc             <= PC_INIT;
            drop           <= 1'b0;
            imem_req_valid <= 1'b0;
            if_valid       <= 1'b0;
            if_instr       <= 32'd0;
            if_pc          <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    state          <= REQ;
                    imem_req_valid <= 1'b1;
                    if (redirect)
                        pc <= target;
                end
                REQ: begin
                    // Before acceptance the address may simply move to the target;
                    // once accepted the outgoing fetch is already stale and must be dropped.
                    if (redirect)
                        pc <= target;
                    if (imem_req_ready) begin
                        state          <= WAIT;
                        imem_req_valid <= 1'b0;
                        if (redirect)
                            drop <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (!drop && !redirect) begin
                            if_instr <= imem_rsp_data;
                            if_pc    <= pc;
                            if_valid <= 1'b1;
                            pc       <= pc + 32'd4;
                            state    <= OUT;
                        end else begin
                            drop           <= 1'b0;
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                            if (redirect)
                                pc <= target;
                        end
                    end else if (redirect) begin
                        pc   <= target;
                        drop <= 1'b1;
                    end
                end
                OUT: begin
                    // A redirect squashes the presented word even if decode takes it.
                    if (redirect) begin
                        if_valid       <= 1'b0;
                        pc             <= target;
                        state          <= REQ;
                        imem_req_valid <= 1'b1;
                    end else if (if_ready) begin
                        if_valid       <= 1'b0;
                        state          <= REQ;
                        imem_req_valid <= 1'b1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    imem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: imem responder, PC-stream scoreboard, redirect-target
// table and directed multi-cycle corner sequences, then randomized traffic.
module tb_fetch_sequencer;

    localparam logic [31:0] RPC = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] redirect_offset = 32'd0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready = 1'b0;
    logic [31:0] pc;

    fetch_sequencer #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect(redirect),
        .redirect_pc(redirect_pc), .redirect_offset(redirect_offset),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_ready(if_ready), .pc(pc)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    int errors = 0;
    int checks = 0;

    // stimulus knobs: 0 = low, 1 = high, 2 = random
    int ready_mode = 0, ifr_mode = 0, dly_min = 0, dly_max = 0;
    bit rnd_redir = 0, redir_req = 0;
    logic [31:0] rq_pc, rq_off;

    // imem responder and scoreboard state
    bit          pending = 0;
    logic [31:0] paddr;
    int          pcnt;
    logic [31:0] exp_pc = RPC;
    int          idle_cyc = 0, delivered = 0;
    logic [31:0] dq[$];

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic pick(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step();
        logic [31:0] r;
        if (imem_req_valid === 1'b1) begin
            chk("req_addr", imem_req_addr, exp_pc);
            chk("single_outstanding", 32'(pending | if_valid), 32'd0);
        end
        if (if_valid === 1'b1) begin
            chk("if_pc", if_pc, exp_pc);
            chk("if_instr", if_instr, hash(if_pc));
            chk("pc_next", pc, if_pc + 32'd4);
        end
        idle_cyc++;
        if (idle_cyc > 60) begin
            checks++; errors++;
            $display("FAIL liveness: no delivery or redirect in %0d cycles", idle_cyc);
            idle_cyc = 0;
        end
        imem_req_ready = pick(ready_mode);
        if_ready       = pick(ifr_mode);
        redirect       = 1'b0;
        if (redir_req) begin
            redirect = 1'b1; redirect_pc = rq_pc; redirect_offset = rq_off; redir_req = 0;
        end else if (rnd_redir && $urandom_range(0, 24) == 0) begin
            redirect = 1'b1;
            r = $urandom;
            redirect_pc = r & ~32'h3;
            r = $urandom;
            redirect_offset = {{20{r[11]}}, r[11:0]};
        end else begin
            redirect_pc = $urandom; redirect_offset = $urandom;
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (pending) begin
            if (pcnt == 0) begin
                imem_rsp_valid = 1'b1; imem_rsp_data = hash(paddr); pending = 0;
            end else pcnt--;
        end
        if (imem_req_valid === 1'b1 && imem_req_ready) begin
            pending = 1; paddr = imem_req_addr; pcnt = $urandom_range(dly_max, dly_min);
        end
        if (redirect) begin
            exp_pc = redirect_pc + (redirect_offset & ~32'h3);
            idle_cyc = 0;
        end else if (if_valid === 1'b1 && if_ready) begin
            dq.push_back(if_pc);
            exp_pc = exp_pc + 32'd4;
            delivered++;
            idle_cyc = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        if_ready = 1'b0; redir_req = 0;
        #1;
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RPC);
        chk("rst_pc", pc, RPC);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0; pending = 0; exp_pc = RPC; idle_cyc = 0;
    endtask

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] roff;
        bit          in_idle;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;
        bit seen_if;
        logic [31:0] sp, si;

        vecs[0] = '{32'h0100_0008, 32'h0000_0013, 1'b0, 32'h0100_0018};
        vecs[1] = '{32'h0000_1000, 32'hFFFF_FFF0, 1'b1, 32'h0000_0FF0};
        vecs[2] = '{32'hFFFF_FFF0, 32'h0000_001F, 1'b0, 32'h0000_000C};
        vecs[3] = '{32'h1234_5678, 32'h0000_0003, 1'b1, 32'h1234_5678};
        vecs[4] = '{32'h0000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000};
        vecs[5] = '{32'h7FFF_FFFC, 32'h0000_0004, 1'b1, 32'h8000_0000};

        @(negedge clk);

        // redirect target arithmetic, applied in IDLE or in REQ before acceptance
        foreach (vecs[i]) begin
            do_reset();
            ready_mode = 0; ifr_mode = 0; rnd_redir = 0;
            if (!vecs[i].in_idle) step();
            rq_pc = vecs[i].rpc; rq_off = vecs[i].roff; redir_req = 1;
            step();
            chk("vec_req_valid", 32'(imem_req_valid), 32'd1);
            chk("vec_target", imem_req_addr, vecs[i].exp_addr);
        end

        // T1: first fetch latency with a zero-wait imem
        do_reset();
        ready_mode = 1; ifr_mode = 0; dly_min = 0; dly_max = 0;
        step();
        chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_req_addr", imem_req_addr, RPC);
        step();
        chk("t1_wait_no_req", 32'(imem_req_valid), 32'd0);
        chk("t1_wait_no_if", 32'(if_valid), 32'd0);
        step();
        chk("t1_if_valid", 32'(if_valid), 32'd1);
        chk("t1_if_pc", if_pc, RPC);

        // T2: four back-to-back fetches, three cycles apiece
        dq.delete(); ifr_mode = 1; n = 0;
        while (dq.size() < 4 && n < 40) begin step(); n++; end
        chk("t2_count", 32'(dq.size()), 32'd4);
        chk("t2_cycles", 32'(n), 32'd10);
        for (int i = 0; i < 4 && i < dq.size(); i++)
            chk("t2_if_pc", dq[i], RPC + 32'(4 * i));

        // T3: decode stalls for five cycles
        ifr_mode = 0; n = 0;
        while (if_valid !== 1'b1 && n < 20) begin step(); n++; end
        chk("t3_reach_out", 32'(if_valid), 32'd1);
        sp = if_pc; si = if_instr;
        repeat (5) begin
            step();
            chk("t3_hold_valid", 32'(if_valid), 32'd1);
            chk("t3_hold_pc", if_pc, sp);
            chk("t3_hold_instr", if_instr, si);
            chk("t3_no_req", 32'(imem_req_valid), 32'd0);
        end
        ifr_mode = 1;

        // T4: redirect while waiting on a slow response
        do_reset();
        ready_mode = 1; ifr_mode = 1; dly_min = 3; dly_max = 3;
        step(); step();
        chk("t4_in_wait", 32'(imem_req_valid), 32'd0);
        rq_pc = 32'h0100_0008; rq_off = 32'h0000_0013; redir_req = 1;
        dq.delete(); seen_if = 0;
        step();
        n = 0;
        while (imem_req_valid !== 1'b1 && n < 20) begin
            if (if_valid === 1'b1) seen_if = 1;
            step(); n++;
        end
        chk("t4_req_addr", imem_req_addr, 32'h0100_0018);
        chk("t4_no_stale_if", 32'(seen_if), 32'd0);
        n = 0;
        while (dq.size() < 1 && n < 30) begin step(); n++; end
        chk("t4_count", 32'(dq.size()), 32'd1);
        if (dq.size() > 0) chk("t4_if_pc", dq[0], 32'h0100_0018);

        // T5: PC wraps past the top of the address space
        dly_min = 0; dly_max = 0;
        rq_pc = 32'hFFFF_FFF0; rq_off = 32'h0000_000C; redir_req = 1;
        dq.delete(); n = 0;
        while (dq.size() < 2 && n < 40) begin step(); n++; end
        chk("t5_count", 32'(dq.size()), 32'd2);
        if (dq.size() > 1) begin
            chk("t5_pc0", dq[0], 32'hFFFF_FFFC);
            chk("t5_pc1", dq[1], 32'h0000_0000);
        end

        // T6: reset in WAIT, reset in OUT, restart, redirect beats if_ready
        do_reset();
        ready_mode = 1; ifr_mode = 0; dly_min = 3; dly_max = 3;
        step(); step();
        do_reset();
        dly_min = 0; dly_max = 0; n = 0;
        while (if_valid !== 1'b1 && n < 10) begin step(); n++; end
        chk("t6_reach_out", 32'(if_valid), 32'd1);
        do_reset();
        step(); step(); step();
        chk("t6_restart_valid", 32'(if_valid), 32'd1);
        chk("t6_restart_pc", if_pc, RPC);
        ifr_mode = 1; rq_pc = 32'h0000_2000; rq_off = 32'h0000_0040; redir_req = 1;
        step();
        chk("t6_squash", 32'(if_valid), 32'd0);
        chk("t6_redir_addr", imem_req_addr, 32'h0000_2040);
        dq.delete(); n = 0;
        while (dq.size() < 1 && n < 30) begin step(); n++; end
        chk("t6_count", 32'(dq.size()), 32'd1);
        if (dq.size() > 0) chk("t6_if_pc", dq[0], 32'h0000_2040);

        // randomized traffic against the scoreboard
        do_reset();
        ready_mode = 2; ifr_mode = 2; dly_min = 0; dly_max = 3; rnd_redir = 1;
        delivered = 0;
        repeat (3000) step();
        chk("rand_progress", 32'(delivered >= 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
